// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the multi-cycle control sequencer: state encoding and trap causes.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } seq_state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// Memory-handshake wait counter; flags expiry on the last permitted wait cycle so the
// sequencer lands in TRAP exactly LIMIT cycles after the request went up.
module seq_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_ready,
    output logic o_expired
);
    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt_reg;

    // Any cycle without an outstanding request, or with the handshake completing,
    // restarts the count so every new request begins from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!i_active || i_ready) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign o_expired = i_active && !i_ready && (cnt_reg == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
// Define SEQ_TIMEOUT_EN to bound each memory handshake to TIMEOUT_CYCLES wait cycles.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_halt,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    input  logic             i_is_load,
    input  logic             i_is_store,
    input  logic             i_is_branch,
    input  logic             i_br_taken,
    input  logic             i_reg_we,
    input  logic             i_illegal,
    output logic             o_imem_req,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic             o_ir_we,
    output logic             o_pc_inc,
    output logic             o_pc_br_we,
    output logic             o_rf_we,
    output logic [2:0]       o_state,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    output logic [CNT_W-1:0] o_instret
);

    seq_state_t       state_reg, state_next;
    logic             req_hold_reg;
    logic             mem_store_reg, mem_store_next;
    logic [1:0]       cause_reg, cause_next;
    logic [CNT_W-1:0] instret_reg;

    logic imem_req_c, dmem_req_c;
    logic ir_we_c, pc_inc_c, pc_br_we_c, rf_we_c;
    logic timeout_expired;
    logic retire;

    // Once a fetch request is up it is held through halt until the memory accepts it.
    assign imem_req_c = (state_reg == ST_FETCH) && (req_hold_reg || !i_halt);
    assign dmem_req_c = (state_reg == ST_MEM);

`ifdef SEQ_TIMEOUT_EN
    logic wait_active, wait_ready;

    assign wait_active = imem_req_c || dmem_req_c;
    assign wait_ready  = (state_reg == ST_MEM) ? i_dmem_ready : i_imem_ready;

    seq_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_active (wait_active),
        .i_ready  (wait_ready),
        .o_expired(timeout_expired)
    );
`else
    // No timer: handshakes wait forever.
    assign timeout_expired = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_next     = state_reg;
        mem_store_next = mem_store_reg;
        cause_next     = cause_reg;
        ir_we_c        = 1'b0;
        pc_inc_c       = 1'b0;
        pc_br_we_c     = 1'b0;
        rf_we_c        = 1'b0;

        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;

            ST_FETCH: begin
                // IR and PC must capture on the accepted beat itself, while fetch data is valid.
                if (imem_req_c && i_imem_ready) begin
                    ir_we_c    = 1'b1;
                    pc_inc_c   = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout_expired) begin
                    cause_next = CAUSE_TIMEOUT;
                    state_next = ST_TRAP;
                end
            end

            ST_DECODE: begin
                if (i_illegal) begin
                    cause_next = CAUSE_ILLEGAL;
                    state_next = ST_TRAP;
                end else begin
                    state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (i_is_branch) begin
                    pc_br_we_c = i_br_taken;
                    state_next = i_reg_we ? ST_WB : ST_FETCH;
                end else if (i_is_load || i_is_store) begin
                    mem_store_next = i_is_store;
                    state_next     = ST_MEM;
                end else if (i_reg_we) begin
                    state_next = ST_WB;
                end else begin
                    state_next = ST_FETCH;
                end
            end

            ST_MEM: begin
                if (i_dmem_ready) begin
                    state_next = mem_store_reg ? ST_FETCH : ST_WB;
                end else if (timeout_expired) begin
                    cause_next = CAUSE_TIMEOUT;
                    state_next = ST_TRAP;
                end
            end

            ST_WB: begin
                rf_we_c    = 1'b1;
                state_next = ST_FETCH;
            end

            ST_TRAP: state_next = ST_TRAP;

            default: state_next = ST_IDLE;
        endcase
    end

    assign retire = (state_next == ST_FETCH) &&
                    ((state_reg == ST_DECODE) || (state_reg == ST_EXEC) ||
                     (state_reg == ST_MEM)    || (state_reg == ST_WB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            req_hold_reg  <= 1'b0;
            mem_store_reg <= 1'b0;
            cause_reg     <= CAUSE_NONE;
            instret_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            req_hold_reg  <= imem_req_c && !i_imem_ready && (state_next == ST_FETCH);
            mem_store_reg <= mem_store_next;
            cause_reg     <= cause_next;
            if (retire) begin
                instret_reg <= instret_reg + CNT_W'(1);
            end
        end
    end

    assign o_imem_req   = imem_req_c;
    assign o_dmem_req   = dmem_req_c;
    assign o_dmem_we    = dmem_req_c && mem_store_reg;
    assign o_ir_we      = ir_we_c;
    assign o_pc_inc     = pc_inc_c;
    assign o_pc_br_we   = pc_br_we_c;
    assign o_rf_we      = rf_we_c;
    assign o_state      = state_reg;
    assign o_trap       = (state_reg == ST_TRAP);
    assign o_trap_cause = cause_reg;
    assign o_instret    = instret_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: per-cycle expectations are queued as stimulus
// is driven and compared on the falling edge. Timeout scenario runs when SEQ_TIMEOUT_EN is defined.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    localparam int CNT_W          = 32;
    localparam int TIMEOUT_CYCLES = 16;

    // Control vector bit positions, msb first.
    localparam logic [7:0] C_IREQ  = 8'h80;
    localparam logic [7:0] C_DREQ  = 8'h40;
    localparam logic [7:0] C_DWE   = 8'h20;
    localparam logic [7:0] C_IRWE  = 8'h10;
    localparam logic [7:0] C_PCINC = 8'h08;
    localparam logic [7:0] C_BRWE  = 8'h04;
    localparam logic [7:0] C_RFWE  = 8'h02;
    localparam logic [7:0] C_TRAP  = 8'h01;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_halt, i_imem_ready, i_dmem_ready;
    logic             i_is_load, i_is_store, i_is_branch, i_br_taken, i_reg_we, i_illegal;
    logic             o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_pc_inc, o_pc_br_we, o_rf_we;
    logic [2:0]       o_state;
    logic             o_trap;
    logic [1:0]       o_trap_cause;
    logic [CNT_W-1:0] o_instret;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_halt      (i_halt),
        .i_imem_ready(i_imem_ready),
        .i_dmem_ready(i_dmem_ready),
        .i_is_load   (i_is_load),
        .i_is_store  (i_is_store),
        .i_is_branch (i_is_branch),
        .i_br_taken  (i_br_taken),
        .i_reg_we    (i_reg_we),
        .i_illegal   (i_illegal),
        .o_imem_req  (o_imem_req),
        .o_dmem_req  (o_dmem_req),
        .o_dmem_we   (o_dmem_we),
        .o_ir_we     (o_ir_we),
        .o_pc_inc    (o_pc_inc),
        .o_pc_br_we  (o_pc_br_we),
        .o_rf_we     (o_rf_we),
        .o_state     (o_state),
        .o_trap      (o_trap),
        .o_trap_cause(o_trap_cause),
        .o_instret   (o_instret)
    );

    typedef struct {
        string            tag;
        logic [2:0]       st;
        logic [7:0]       ctl;
        logic [1:0]       cause;
        logic [CNT_W-1:0] instret;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             cur;
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_instret = '0;
    logic [1:0]       exp_cause   = 2'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_eq({cur.tag, "/state"}, 64'(o_state), 64'(cur.st));
            check_eq({cur.tag, "/ctl"},
                     64'({o_imem_req, o_dmem_req, o_dmem_we, o_ir_we,
                          o_pc_inc, o_pc_br_we, o_rf_we, o_trap}), 64'(cur.ctl));
            check_eq({cur.tag, "/cause"}, 64'(o_trap_cause), 64'(cur.cause));
            check_eq({cur.tag, "/instret"}, 64'(o_instret), 64'(cur.instret));
        end
    end

    // Queue this cycle's expectation (inputs already driven), then advance one clock.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] ctl);
        exp_t e;
        e.tag     = tag;
        e.st      = st;
        e.ctl     = ctl;
        e.cause   = exp_cause;
        e.instret = exp_instret;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string name, input logic ld, input logic st_f,
                             input logic br, input logic tk, input logic rw, input logic ill,
                             input int halt_pre, input int iwait, input int dwait,
                             input logic halt_mid);
        logic do_wb;
        i_is_load   = ld;
        i_is_store  = st_f;
        i_is_branch = br;
        i_br_taken  = tk;
        i_reg_we    = rw;
        i_illegal   = ill;
        i_dmem_ready = 1'b0;
        for (int k = 0; k < halt_pre; k++) begin
            i_halt       = 1'b1;
            i_imem_ready = 1'b1;
            cyc({name, "/halt"}, ST_FETCH, 8'h00);
        end
        i_halt       = 1'b0;
        i_imem_ready = 1'b0;
        for (int k = 0; k < iwait; k++) begin
            if (halt_mid && k > 0) i_halt = 1'b1;
            cyc({name, "/fwait"}, ST_FETCH, C_IREQ);
        end
        i_imem_ready = 1'b1;
        if (halt_mid) i_halt = 1'b1;
        cyc({name, "/fetch"}, ST_FETCH, C_IREQ | C_IRWE | C_PCINC);
        i_imem_ready = 1'b0;
        i_halt       = 1'b0;
        cyc({name, "/decode"}, ST_DECODE, 8'h00);
        if (ill) begin
            exp_cause = 2'd1;
            $display("txn %s trapped instret=%0d", name, exp_instret);
            return;
        end
        cyc({name, "/exec"}, ST_EXEC, (br && tk) ? C_BRWE : 8'h00);
        if (!br && (ld || st_f)) begin
            for (int k = 0; k < dwait; k++) begin
                cyc({name, "/mwait"}, ST_MEM, C_DREQ | (st_f ? C_DWE : 8'h00));
            end
            i_dmem_ready = 1'b1;
            cyc({name, "/mem"}, ST_MEM, C_DREQ | (st_f ? C_DWE : 8'h00));
            i_dmem_ready = 1'b0;
        end
        do_wb = br ? rw : (ld ? 1'b1 : (st_f ? 1'b0 : rw));
        if (do_wb) cyc({name, "/wb"}, ST_WB, C_RFWE);
        exp_instret++;
        $display("txn %s retired instret=%0d", name, exp_instret);
    endtask

    initial begin
        rst_n = 1'b0;
        i_halt = 1'b0; i_imem_ready = 1'b0; i_dmem_ready = 1'b0;
        i_is_load = 1'b0; i_is_store = 1'b0; i_is_branch = 1'b0;
        i_br_taken = 1'b0; i_reg_we = 1'b0; i_illegal = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", ST_IDLE, 8'h00);
        cyc("reset", ST_IDLE, 8'h00);
        rst_n = 1'b1;
        cyc("release", ST_IDLE, 8'h00);

        //         name        ld   st   br   tk   rw   ill  hpre iw dw hmid
        run_instr("addu",     0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        run_instr("lw_d3",    1, 0, 0, 0, 1, 0, 0, 0, 3, 0);
        run_instr("sw",       0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("sw_d2",    0, 1, 0, 0, 0, 0, 0, 0, 2, 0);
        run_instr("beq_tk",   0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        run_instr("beq_nt",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr("jal",      0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        run_instr("br_prio",  1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr("nop",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("halt_pre", 0, 0, 0, 0, 1, 0, 5, 0, 0, 0);
        run_instr("halt_mid", 0, 0, 0, 0, 1, 0, 0, 3, 0, 1);
        run_instr("lw_iw1",   1, 0, 0, 0, 1, 0, 0, 1, 0, 0);

        // Reset in the middle of a fetch handshake drops the request at once.
        i_halt = 1'b0; i_imem_ready = 1'b0;
        cyc("rmh/fwait", ST_FETCH, C_IREQ);
        cyc("rmh/fwait", ST_FETCH, C_IREQ);
        rst_n = 1'b0;
        exp_instret = '0;
        cyc("rmh/reset", ST_IDLE, 8'h00);
        rst_n = 1'b1;
        cyc("rmh/release", ST_IDLE, 8'h00);
        run_instr("addu_r", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

`ifdef SEQ_TIMEOUT_EN
        i_is_load = 1'b1; i_is_store = 1'b0; i_is_branch = 1'b0;
        i_br_taken = 1'b0; i_reg_we = 1'b1; i_illegal = 1'b0;
        i_imem_ready = 1'b1;
        cyc("tmo/fetch", ST_FETCH, C_IREQ | C_IRWE | C_PCINC);
        i_imem_ready = 1'b0;
        i_dmem_ready = 1'b0;
        cyc("tmo/decode", ST_DECODE, 8'h00);
        cyc("tmo/exec", ST_EXEC, 8'h00);
        for (int k = 0; k < TIMEOUT_CYCLES; k++) cyc("tmo/mwait", ST_MEM, C_DREQ);
        exp_cause = 2'd2;
        for (int k = 0; k < 3; k++) cyc("tmo/trap", ST_TRAP, C_TRAP);
        $display("txn timeout trapped instret=%0d", exp_instret);
        rst_n = 1'b0;
        exp_instret = '0;
        exp_cause   = 2'd0;
        cyc("tmo/reset", ST_IDLE, 8'h00);
        rst_n = 1'b1;
        cyc("tmo/release", ST_IDLE, 8'h00);
`endif

        run_instr("illegal", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        i_illegal = 1'b0; i_imem_ready = 1'b1; i_dmem_ready = 1'b1;
        i_is_load = 1'b1; i_reg_we = 1'b1; i_is_branch = 1'b1; i_br_taken = 1'b1;
        for (int k = 0; k < 20; k++) cyc("trap", ST_TRAP, C_TRAP);
        rst_n = 1'b0;
        exp_instret = '0;
        exp_cause   = 2'd0;
        cyc("trap/reset", ST_IDLE, 8'h00);
        rst_n = 1'b1;
        cyc("trap/release", ST_IDLE, 8'h00);
        run_instr("addu_post", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        check_eq("drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
